// File: rtl/shift_in_loader.sv
// Assembles DATA_W-wide input beats into a WORD_W-wide registered word.
// Latency: out_valid rises one cycle after the beat that completes the word.
// Backpressure: in_ready drops while a complete word waits for out_ready, and whenever clear is high.
//
// Ports:
//   clk, reset_n          sole clock (rising edge); asynchronous active-low reset
//   clear                 synchronous abort, discards any partial or held word
//   in_valid/in_ready     input beat handshake, in_data carries the beat
//   out_valid/out_ready   completed word handshake, out_word carries the word
//   beat_cnt              beats accepted into the current word (BEATS while held)
module shift_in_loader #(
  parameter int DATA_W    = 8,
  parameter int WORD_W    = 512,
  parameter bit MSB_FIRST = 1'b1,
  localparam int BEATS    = WORD_W / DATA_W,
  localparam int CNT_W    = $clog2(BEATS + 1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_word,
  output logic [CNT_W-1:0]  beat_cnt
);

  generate
    if ((WORD_W % DATA_W) != 0 || WORD_W < DATA_W) begin : g_bad_width
      $error("shift_in_loader: WORD_W must be a non-zero integer multiple of DATA_W");
    end
  endgenerate

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  // Count value held by the beat that completes the word, before it is accepted.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic [WORD_W-1:0]   shifted;

  // Word after shifting in the current beat; orientation chosen at elaboration.
  generate
    if (BEATS == 1) begin : g_single
      assign shifted = in_data;
    end else if (MSB_FIRST) begin : g_msb
      assign shifted = {word_q[WORD_W-DATA_W-1:0], in_data};
    end else begin : g_lsb
      assign shifted = {in_data, word_q[WORD_W-1:DATA_W]};
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    // clear outranks both the input beat and the output handshake.
    if (clear) begin
      state_d = FILL;
      cnt_d   = '0;
      word_d  = '0;
    end else begin
      case (state_q)
        FILL: begin
          if (in_valid) begin
            word_d = shifted;
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == LAST_CNT) begin
              state_d = HOLD;
            end
          end
        end
        HOLD: begin
          // Word is left in place after the handshake; the next beat shifts it out.
          if (out_ready) begin
            state_d = FILL;
            cnt_d   = '0;
          end
        end
        default: state_d = FILL;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= FILL;
      cnt_q   <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
    end
  end

  assign in_ready  = (state_q == FILL) && !clear;
  assign out_valid = (state_q == HOLD);
  assign out_word  = word_q;
  assign beat_cnt  = cnt_q;

endmodule

// File: tb/tb_shift_in_loader.sv
`timescale 1ns/100ps
module tb_shift_in_loader;

  logic clk = 1'b0;
  logic reset_n;
  logic clear, in_valid, out_ready;
  logic [7:0] in_data;

  logic m_in_ready, m_out_valid;
  logic [31:0] m_word;
  logic [2:0] m_cnt;
  logic l_in_ready, l_out_valid;
  logic [31:0] l_word;
  logic [2:0] l_cnt;

  logic d_valid, d_oready, d_clear;
  logic [7:0] d_data;
  logic d_in_ready, d_out_valid;
  logic [511:0] d_word;
  logic [6:0] d_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  shift_in_loader #(.DATA_W(8), .WORD_W(32), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .reset_n(reset_n), .clear(clear), .in_valid(in_valid), .in_data(in_data),
    .in_ready(m_in_ready), .out_valid(m_out_valid), .out_ready(out_ready),
    .out_word(m_word), .beat_cnt(m_cnt));

  shift_in_loader #(.DATA_W(8), .WORD_W(32), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .reset_n(reset_n), .clear(clear), .in_valid(in_valid), .in_data(in_data),
    .in_ready(l_in_ready), .out_valid(l_out_valid), .out_ready(out_ready),
    .out_word(l_word), .beat_cnt(l_cnt));

  shift_in_loader dut_d (
    .clk(clk), .reset_n(reset_n), .clear(d_clear), .in_valid(d_valid), .in_data(d_data),
    .in_ready(d_in_ready), .out_valid(d_out_valid), .out_ready(d_oready),
    .out_word(d_word), .beat_cnt(d_cnt));

  // Reference model: the word is simply the last four accepted bytes since the
  // most recent clear/reset (zeros before that), and a word is complete once
  // four beats have been taken since the last handshake.
  logic [7:0] hist [4] = '{default: 8'h00};
  int  mc  = 0;
  bit  mh  = 1'b0;
  int  dc  = 0;
  int  dtot = 0;
  bit  dh  = 1'b0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) hist[i] <= 8'h00;
      mc <= 0; mh <= 1'b0;
      dc <= 0; dtot <= 0; dh <= 1'b0;
    end else begin
      if (clear) begin
        for (int i = 0; i < 4; i++) hist[i] <= 8'h00;
        mc <= 0; mh <= 1'b0;
      end else if (mh) begin
        if (out_ready) begin mh <= 1'b0; mc <= 0; end
      end else if (in_valid) begin
        for (int i = 0; i < 3; i++) hist[i] <= hist[i+1];
        hist[3] <= in_data;
        mc <= mc + 1;
        mh <= (mc + 1 == 4);
      end
      if (dh) begin
        if (d_oready) begin dh <= 1'b0; dc <= 0; end
      end else if (d_valid) begin
        dc <= dc + 1;
        if (dtot < 64) dtot <= dtot + 1;
        dh <= (dc + 1 == 64);
      end
    end
  end

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Every-cycle comparison of all three instances against the model.
  always @(negedge clk) begin
    logic [511:0] ones;
    ones = '1;
    chk("m_word",  m_word, {hist[0], hist[1], hist[2], hist[3]});
    chk("l_word",  l_word, {hist[3], hist[2], hist[1], hist[0]});
    chk("m_cnt",   m_cnt, mc);
    chk("l_cnt",   l_cnt, mc);
    chk("m_valid", m_out_valid, mh);
    chk("l_valid", l_out_valid, mh);
    chk("m_ready", m_in_ready, !mh && !clear);
    chk("l_ready", l_in_ready, !mh && !clear);
    chk("d_word",  d_word, (dtot == 0) ? 512'd0 : (ones >> (512 - 8 * dtot)));
    chk("d_cnt",   d_cnt, dc);
    chk("d_valid", d_out_valid, dh);
    chk("d_ready", d_in_ready, !dh);
  end

  // Hold the given inputs across exactly one rising edge.
  task automatic drive(input logic v, input logic [7:0] d, input logic c, input logic o);
    in_valid = v; in_data = d; clear = c; out_ready = o;
    @(posedge clk); #1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    d_valid = 1'b0; d_data = 8'h00; d_oready = 1'b0; d_clear = 1'b0;
    #12 reset_n = 1'b1;
    #1;
    chk("rst_valid", m_out_valid, 1'b0);
    chk("rst_cnt",   m_cnt, 3'd0);
    chk("rst_ready", m_in_ready, 1'b1);
    chk("rst_word",  m_word, 32'h0);
    @(posedge clk); #1;

    // Back-to-back word, both orientations.
    drive(1, 8'h11, 0, 0); drive(1, 8'h22, 0, 0); drive(1, 8'h33, 0, 0); drive(1, 8'h44, 0, 0);
    chk("msb_word",   m_word, 32'h11223344);
    chk("lsb_word",   l_word, 32'h44332211);
    chk("hold_valid", m_out_valid, 1'b1);
    chk("hold_ready", m_in_ready, 1'b0);

    // Held word ignores incoming beats until the handshake.
    for (int i = 0; i < 5; i++) drive(1, 8'hAA, 0, 0);
    chk("hold_word", m_word, 32'h11223344);
    chk("hold_cnt",  m_cnt, 3'd4);
    drive(0, 8'h00, 0, 1);
    chk("hs_valid", m_out_valid, 1'b0);
    chk("hs_cnt",   m_cnt, 3'd0);
    chk("hs_keep",  m_word, 32'h11223344);

    // Clear mid-word with a beat presented.
    drive(1, 8'h55, 0, 0); drive(1, 8'h66, 0, 0);
    drive(1, 8'h77, 1, 0);
    chk("clr_cnt",  m_cnt, 3'd0);
    chk("clr_word", m_word, 32'h0);
    drive(1, 8'h01, 0, 0); drive(1, 8'h02, 0, 0); drive(1, 8'h03, 0, 0); drive(1, 8'h04, 0, 0);
    chk("after_clr_msb", m_word, 32'h01020304);
    chk("after_clr_lsb", l_word, 32'h04030201);

    // Clear beats a handshake presented in the same cycle.
    drive(0, 8'h00, 1, 1);
    chk("clr_hold_word",  m_word, 32'h0);
    chk("clr_hold_valid", m_out_valid, 1'b0);

    // Asynchronous reset between edges after three beats.
    drive(1, 8'hC1, 0, 0); drive(1, 8'hC2, 0, 0); drive(1, 8'hC3, 0, 0);
    in_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("arst_word",  m_word, 32'h0);
    chk("arst_cnt",   m_cnt, 3'd0);
    chk("arst_valid", m_out_valid, 1'b0);
    #0.5 reset_n = 1'b1;
    @(posedge clk); #1;
    chk("arst_ready", m_in_ready, 1'b1);
    drive(1, 8'hA1, 0, 0); drive(1, 8'hA2, 0, 0); drive(1, 8'hA3, 0, 0); drive(1, 8'hA4, 0, 0);
    chk("arst_new", m_word, 32'hA1A2A3A4);
    drive(0, 8'h00, 0, 1);

    // Random traffic with gaps, stalls, occasional clear; in_data toggles while idle.
    for (int i = 0; i < 600; i++) begin
      drive(1'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 19) == 0),
            1'($urandom_range(0, 1)));
    end
    drive(0, 8'h00, 0, 0);

    // Default geometry: 64 beats of 0xFF with random gaps, twice.
    for (int r = 0; r < 2; r++) begin
      int n;
      n = 0;
      while (!dh && n < 3000) begin
        d_valid = 1'($urandom_range(0, 1));
        d_data  = d_valid ? 8'hFF : 8'($urandom);
        @(posedge clk); #1;
        n++;
      end
      d_valid = 1'b0;
      chk("d_timeout", dh, 1'b1);
      chk("d_full_word",  d_word, {512{1'b1}});
      chk("d_full_cnt",   d_cnt, 7'd64);
      chk("d_full_valid", d_out_valid, 1'b1);
      @(posedge clk); #1;
      d_oready = 1'b1;
      @(posedge clk); #1;
      d_oready = 1'b0;
      chk("d_hs_valid", d_out_valid, 1'b0);
      chk("d_hs_cnt",   d_cnt, 7'd0);
    end

    @(posedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/shift_in_loader.md
SHIFT_IN_LOADER -- requirements
Module: shift_in_loader

Interface
REQ-001 Parameter DATA_W, default 8, width of one input beat in bits.
REQ-002 Parameter WORD_W, default 512, width of the assembled word in bits; SHALL be an integer multiple of DATA_W, otherwise elaboration fails.
REQ-003 Parameter MSB_FIRST, default 1; 1 = first beat lands in the most significant slice, 0 = first beat lands in the least significant slice.
REQ-004 Derived constant BEATS = WORD_W/DATA_W; CNT_W = clog2(BEATS+1).
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 clear  input  1  synchronous abort; discards any partial or held word.
REQ-008 in_valid  input  1  in_data carries a beat this cycle.
REQ-009 in_data  input  DATA_W  input beat.
REQ-010 in_ready  output  1  block accepts a beat this cycle.
REQ-011 out_valid  output  1  out_word holds a complete assembled word.
REQ-012 out_ready  input  1  consumer takes the word this cycle.
REQ-013 out_word  output  WORD_W  assembled word (registered).
REQ-014 beat_cnt  output  CNT_W  number of beats accepted into the current word.

Function
REQ-015 Two states: FILL (collecting beats) and HOLD (complete word presented).
REQ-016 in_ready SHALL be 1 in FILL and 0 in HOLD, with clear deasserted; in_ready SHALL be 0 in any cycle where clear=1.
REQ-017 A beat is accepted when in_valid=1 and in_ready=1 on a rising clk edge; beat_cnt increments by 1.
REQ-018 MSB_FIRST=1: on accept, out_word <= {out_word[WORD_W-DATA_W-1:0], in_data}.
REQ-019 MSB_FIRST=0: on accept, out_word <= {in_data, out_word[WORD_W-1:DATA_W]}.
REQ-020 When the accepted beat makes beat_cnt reach BEATS, state SHALL go to HOLD and out_valid SHALL be 1 from the next cycle (1-cycle latency after the last beat); beat_cnt reads BEATS in HOLD.
REQ-021 In HOLD, out_word and beat_cnt SHALL stay stable until a handshake (out_valid=1 and out_ready=1).
REQ-022 On handshake: state -> FILL, out_valid -> 0, beat_cnt -> 0; out_word retains its value until the next accepted beat shifts it; no beat is accepted in the handshake cycle.
REQ-023 in_valid=0 in FILL: no state, count or data change (stalls of any length are allowed between beats).
REQ-024 out_ready in FILL is ignored.
REQ-025 clear=1 SHALL, on the next edge and with priority over every handshake: out_word -> 0, beat_cnt -> 0, out_valid -> 0, state -> FILL; a beat or handshake presented in the same cycle is discarded/ignored.
REQ-026 in_data X/changes while in_valid=0 SHALL NOT affect any output.

Reset
REQ-027 reset_n=0 SHALL immediately, independent of clk: state FILL, out_word 0, beat_cnt 0, out_valid 0; in_ready reads 1 once reset_n=1 (with clear=0).
REQ-028 Reset asserted mid-word or in HOLD SHALL discard all data; the first beat after release starts a new word.
REQ-029 Reset deassertion is synchronised by the integrator; the block needs no internal synchroniser.

Verification (WORD_W=32, DATA_W=8 unless noted)
REQ-030 MSB_FIRST=1, beats 0x11,0x22,0x33,0x44 back-to-back -> out_valid=1 one cycle after 4th accept, out_word=0x11223344, in_ready=0.
REQ-031 MSB_FIRST=0, same beats -> out_word=0x44332211.
REQ-032 In HOLD with out_ready=0 for 5 cycles, in_valid=1 with 0xAA -> out_word unchanged, beat_cnt=4, no accept; then out_ready=1 -> out_valid=0, beat_cnt=0 next cycle.
REQ-033 Two beats accepted, then clear=1 with in_valid=1 -> beat_cnt=0, out_word=0, beat discarded; next 4 beats 0x01..0x04 give 0x01020304.
REQ-034 reset_n pulsed low asynchronously (between edges) after 3 beats -> outputs zero immediately, in_ready=1 after release.
REQ-035 Defaults (DATA_W=8, WORD_W=512), 64 beats of 0xFF with random in_valid gaps -> out_word all ones, out_valid only after 64th accept.
